// File: rtl/mips_bus_master.sv
// Avalon-MM bus master shared by the CPU memory requestors: arbitrates NUM_PORTS
// ports and runs one transaction at a time with byte-lane steering and load extension.
module mips_bus_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_PORTS = 2,
  parameter int ARB_RR    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [2*NUM_PORTS-1:0]      req_size,
  input  logic [NUM_PORTS-1:0]        req_signed,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_grant,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_err,
  output logic                        busy,
  output logic [ADDR_W-1:0]           address,
  output logic                        read,
  output logic                        write,
  input  logic                        waitrequest,
  output logic [DATA_W-1:0]           writedata,
  output logic [DATA_W/8-1:0]         byteenable,
  input  logic [DATA_W-1:0]           readdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RCAPT, RESP} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  port_q, port_d, rr_ptr_q, rr_ptr_d;
  logic              write_q, write_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NB-1:0]     be_q, be_d;

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    return NB'(((32'd1 << (32'd1 << size)) - 32'd1) << lane);
  endfunction

  // Byte k of the bus carries byte (k mod 2^size) of the right-justified store data.
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    logic [LANE_W-1:0] m, src;
    r = '0;
    m = LANE_W'((32'd1 << size) - 32'd1);
    for (int k = 0; k < NB; k++) begin
      src = LANE_W'(k) & m;
      r[8*k +: 8] = d[8*src +: 8];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [1:0] size, input logic [LANE_W-1:0] lane,
                                                input logic sgn, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] s, r;
    logic              fill;
    s = d >> {lane, 3'b000};
    case (size)
      2'd0:    fill = s[7];
      2'd1:    fill = s[15];
      2'd2:    fill = s[31];
      default: fill = s[DATA_W-1];
    endcase
    fill = fill & sgn;
    for (int k = 0; k < NB; k++) begin
      r[8*k +: 8] = (k < (1 << size)) ? s[8*k +: 8] : {8{fill}};
    end
    return r;
  endfunction

  // Arbitration: search from port 0 (fixed) or from the round-robin pointer.
  logic             found;
  logic [PTR_W-1:0] win, idx;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (ARB_RR != 0) ? PTR_W'((int'(rr_ptr_q) + i) % NUM_PORTS) : PTR_W'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        low_mask;
  logic              legal;
  assign sel_size  = req_size[2*win +: 2];
  assign sel_addr  = req_addr[ADDR_W*win +: ADDR_W];
  assign sel_wdata = req_wdata[DATA_W*win +: DATA_W];
  assign low_mask  = 3'((4'd1 << sel_size) - 4'd1);
  assign legal     = ((sel_addr[2:0] & low_mask) == 3'd0) && !((sel_size == 2'd3) && (DATA_W == 32));

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    rr_ptr_d  = rr_ptr_q;
    write_d   = write_q;
    signed_d  = signed_q;
    err_d     = err_q;
    size_d    = size_q;
    lane_d    = lane_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    be_d      = be_q;
    req_grant = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_grant[win] = 1'b1;
          port_d   = win;
          write_d  = req_write[win];
          signed_d = req_signed[win];
          size_d   = sel_size;
          lane_d   = sel_addr[LANE_W-1:0];
          if (ARB_RR != 0) rr_ptr_d = PTR_W'((int'(win) + 1) % NUM_PORTS);
          if (legal) begin
            err_d     = 1'b0;
            address_d = sel_addr & ~ADDR_W'(NB - 1);
            be_d      = lane_mask(sel_size, sel_addr[LANE_W-1:0]);
            wdata_d   = replicate(sel_size, sel_wdata);
            state_d   = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: if (!waitrequest) state_d = write_q ? RESP : RCAPT;
      RCAPT: begin
        rdata_d = extract(size_q, lane_q, signed_q, readdata);
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      port_q    <= '0;
      rr_ptr_q  <= '0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      rr_ptr_q  <= rr_ptr_d;
      write_q   <= write_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      size_q    <= size_d;
      lane_q    <= lane_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      be_q      <= be_d;
    end
  end

  // Strobes decode directly from state so an asynchronous reset drops them at once.
  assign read       = (state_q == ACCESS) && !write_q;
  assign write      = (state_q == ACCESS) && write_q;
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP) ? (NUM_PORTS'(1) << port_q) : '0;
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign address    = address_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Self-checking bench for mips_bus_master: directed vector table, arbitration and
// reset sequences, then randomized transactions against an arithmetic reference model.
module tb_mips_bus_master;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_valid_rr, req_write, req_signed;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [1:0]  req_grant, resp_valid;
  logic [31:0] resp_rdata, address, writedata;
  logic        resp_err, busy, read, write;
  logic [3:0]  byteenable;

  logic [1:0]  rr_grant, rr_resp_valid;
  logic [31:0] rr_resp_rdata, rr_address, rr_writedata;
  logic        rr_resp_err, rr_busy, rr_read, rr_write;
  logic [3:0]  rr_byteenable;

  int errors = 0;
  int checks = 0;

  mips_bus_master #(.DATA_W(32), .ADDR_W(32), .NUM_PORTS(2), .ARB_RR(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  mips_bus_master #(.DATA_W(32), .ADDR_W(32), .NUM_PORTS(2), .ARB_RR(1)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid_rr), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(rr_grant), .resp_valid(rr_resp_valid), .resp_rdata(rr_resp_rdata), .resp_err(rr_resp_err),
    .busy(rr_busy), .address(rr_address), .read(rr_read), .write(rr_write), .waitrequest(waitrequest),
    .writedata(rr_writedata), .byteenable(rr_byteenable), .readdata(readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on sizes in bytes.
  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'd3) || ((addr % (32'd1 << sz)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
    longint unsigned v;
    v = ((64'd1 << (64'd1 << sz)) - 64'd1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wdata);
    longint unsigned nbytes, val, r;
    nbytes = 64'd1 << sz;
    val    = 64'(wdata) & ((64'd1 << (8 * nbytes)) - 64'd1);
    r      = 0;
    for (longint unsigned k = 0; k < 4 / nbytes; k++) r = r | (val << (8 * nbytes * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint unsigned nbits, v;
    nbits = 64'd8 << sz;
    v = (64'(rd) >> (8 * (addr % 4))) & ((64'd1 << nbits) - 64'd1);
    if (sg && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
    return v[31:0];
  endfunction

  // Issue one request on the fixed-priority instance and observe it to completion.
  task automatic run_txn(input string nm, input int port, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int waits, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat);
    int   resp_cyc, strobes;
    logic bus_ok, overlap;
    logic [1:0]  got_valid;
    logic        got_err;
    logic [31:0] got_rd;
    resp_cyc = -1; strobes = 0; bus_ok = 1'b1; overlap = 1'b0;
    got_valid = '0; got_err = 1'b0; got_rd = '0;
    req_valid = '0;
    req_valid[port] = 1'b1;
    req_write[port] = wr;
    req_signed[port] = sg;
    req_size[2*port +: 2] = sz;
    req_addr[32*port +: 32] = addr;
    req_wdata[32*port +: 32] = wdata;
    waitrequest = (waits > 0);
    readdata = $urandom;
    @(negedge clk);
    check({nm, " grant"}, 64'(req_grant), 64'(2'b01 << port));
    tick();
    req_valid = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      waitrequest = (cyc <= waits);
      readdata = (cyc == waits + 2) ? rd : $urandom;
      @(negedge clk);
      if (read && write) overlap = 1'b1;
      if (read || write) begin
        strobes++;
        if (write !== wr || address !== (addr & ~32'h3) || byteenable !== exp_be ||
            (wr && writedata !== exp_wd)) bus_ok = 1'b0;
      end
      if (resp_valid != 2'b00) begin
        resp_cyc = cyc; got_valid = resp_valid; got_err = resp_err; got_rd = resp_rdata;
        break;
      end
      tick();
    end
    check({nm, " resp cycle"}, 64'(resp_cyc), 64'(exp_lat));
    check({nm, " strobe cycles"}, 64'(strobes), exp_err ? 64'd0 : 64'(waits + 1));
    check({nm, " bus fields"}, 64'(bus_ok), 64'd1);
    check({nm, " strobe overlap"}, 64'(overlap), 64'd0);
    check({nm, " resp_valid port"}, 64'(got_valid), 64'(2'b01 << port));
    check({nm, " resp_err"}, 64'(got_err), 64'(exp_err));
    if (!wr && !exp_err) check({nm, " resp_rdata"}, 64'(got_rd), 64'(exp_rd));
    tick();
    @(negedge clk);
    check({nm, " idle after resp"}, {62'd0, busy, |resp_valid}, 64'd0);
    tick();
  endtask

  typedef struct {
    string       nm;
    int          port;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr, wdata, rd;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wd, rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  int   g_fixed[$];
  int   g_rr[$];
  int   exp_rr[4] = '{0, 1, 0, 1};
  logic reset_ok;

  initial begin
    vecs[0]  = '{"sw_0x104",   0, 1'b1, 2'd2, 1'b0, 32'h104,  32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[1]  = '{"sb_0x103",   1, 1'b1, 2'd0, 1'b0, 32'h103,  32'h000000AB, 32'h0,        0, 4'h8, 32'hABABABAB, 32'h0,        1'b0, 2};
    vecs[2]  = '{"lh_s_0x102", 0, 1'b0, 2'd1, 1'b1, 32'h102,  32'h0,        32'h80FF1234, 0, 4'hC, 32'h0,        32'hFFFF80FF, 1'b0, 3};
    vecs[3]  = '{"lw_wait3",   1, 1'b0, 2'd2, 1'b0, 32'h200,  32'h0,        32'h12345678, 3, 4'hF, 32'h0,        32'h12345678, 1'b0, 6};
    vecs[4]  = '{"lh_misalign",0, 1'b0, 2'd1, 1'b0, 32'h101,  32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
    vecs[5]  = '{"lb_u_0x101", 1, 1'b0, 2'd0, 1'b0, 32'h101,  32'h0,        32'h0000F100, 0, 4'h2, 32'h0,        32'h000000F1, 1'b0, 3};
    vecs[6]  = '{"lb_s_0x101", 0, 1'b0, 2'd0, 1'b1, 32'h101,  32'h0,        32'h0000F100, 0, 4'h2, 32'h0,        32'hFFFFFFF1, 1'b0, 3};
    vecs[7]  = '{"sh_wait1",   1, 1'b1, 2'd1, 1'b0, 32'h1236, 32'h99997788, 32'h0,        1, 4'hC, 32'h77887788, 32'h0,        1'b0, 3};
    vecs[8]  = '{"dword_ill",  0, 1'b0, 2'd3, 1'b0, 32'h100,  32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{"sw_misalign",1, 1'b1, 2'd2, 1'b0, 32'h102,  32'h11223344, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
    vecs[10] = '{"lh_u_wait2", 0, 1'b0, 2'd1, 1'b0, 32'h100,  32'h0,        32'hFFFF8001, 2, 4'h3, 32'h0,        32'h00008001, 1'b0, 5};
    vecs[11] = '{"sb_0x100",   1, 1'b1, 2'd0, 1'b0, 32'h100,  32'h12345680, 32'h0,        0, 4'h1, 32'h80808080, 32'h0,        1'b0, 2};

    req_valid = '0; req_valid_rr = '0; req_write = '0; req_signed = '0;
    req_size = '0; req_addr = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset strobes/flags", {58'd0, read, write, busy, resp_err, req_grant}, 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset bus regs", {address, writedata}, 64'd0);
    check("reset be/rdata", {28'd0, byteenable, resp_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    foreach (vecs[i])
      run_txn(vecs[i].nm, vecs[i].port, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr,
              vecs[i].wdata, vecs[i].rd, vecs[i].waits, vecs[i].be, vecs[i].wd, vecs[i].rdata,
              vecs[i].err, vecs[i].lat);

    // Both ports requesting continuously on both arbitration modes.
    req_write = 2'b11; req_size = 4'b1010; req_addr = '0; req_wdata = '0; waitrequest = 1'b0;
    req_valid = 2'b11; req_valid_rr = 2'b11;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (req_grant != 2'b00) g_fixed.push_back(req_grant[1] ? 1 : 0);
      if (rr_grant != 2'b00) g_rr.push_back(rr_grant[1] ? 1 : 0);
      tick();
    end
    req_valid = '0; req_valid_rr = '0;
    check("fixed grant count", 64'(g_fixed.size()), 64'd4);
    check("rr grant count", 64'(g_rr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_fixed.size()) check($sformatf("fixed grant %0d", i), 64'(g_fixed[i]), 64'd0);
      if (i < g_rr.size()) check($sformatf("rr grant %0d", i), 64'(g_rr[i]), 64'(exp_rr[i]));
    end
    repeat (2) tick();

    // Reset while a load is stalled in ACCESS.
    req_write = '0; req_size = 4'b1010; req_addr = {32'h0, 32'h200}; req_valid = 2'b01; waitrequest = 1'b1;
    @(negedge clk);
    check("abort grant", 64'(req_grant), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("abort read before reset", 64'(read), 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort strobes drop", {61'd0, read, write, busy}, 64'd0);
    reset_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid != 2'b00) reset_ok = 1'b0;
    end
    check("abort no response", 64'(reset_ok), 64'd1);
    reset = 1'b1;
    waitrequest = 1'b0;
    tick();
    run_txn("after_reset_sw", 0, 1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 0,
            4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 2);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      int          port, waits, lat;
      logic        wr, sg, err;
      logic [1:0]  sz;
      logic [31:0] addr, wdata, rd;
      port  = $urandom_range(0, 1);
      wr    = 1'($urandom_range(0, 1));
      sg    = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      waits = $urandom_range(0, 3);
      addr  = $urandom & 32'h0000FFFF;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      wdata = $urandom;
      rd    = $urandom;
      err   = m_err(sz, addr);
      lat   = err ? 1 : (wr ? 2 + waits : 3 + waits);
      run_txn($sformatf("rand%0d", n), port, wr, sz, sg, addr, wdata, rd, waits,
              m_be(sz, addr), m_wd(sz, wdata), m_load(sz, sg, addr, rd), err, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
